// File: rtl/mario_pkg.sv
// Types and playfield constants shared by the horizontal/vertical motion and collision blocks.
package mario_pkg;

    typedef logic [17:0] coord_t;

    typedef enum logic [1:0] {
        STAND = 2'd0,
        RUN_R = 2'd1,
        RUN_L = 2'd2,
        SKID  = 2'd3
    } x_state_t;

    localparam int unsigned SCROLL_X    = 320;
    localparam int unsigned LEFT_BOUND  = 16;
    localparam int unsigned RIGHT_BOUND = 624;
    localparam int unsigned MAX_OFFSET  = 6564;

endpackage

// File: rtl/x_speed_ramp.sv
// Frame-tick step counter plus saturating speed register for the horizontal motion FSM.
module x_speed_ramp
    import mario_pkg::*;
#(
    parameter int unsigned MAX_SPEED    = 4,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       clear_i,
    input  logic       restart_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [2:0] speed_o,
    output logic [2:0] speed_d_o,
    output logic       step_o
);

    localparam logic [7:0] AF_LAST = 8'(ACCEL_FRAMES - 1);
    localparam logic [2:0] SMAX    = 3'(MAX_SPEED);

    logic [2:0] speed_q, speed_d;
    logic [7:0] cnt_q, cnt_d;

    assign step_o = (cnt_q == AF_LAST);

    // restart clears the counter; with inc it also takes the immediate first step
    always_comb begin
        speed_d = speed_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (clear_i) begin
                speed_d = '0;
                cnt_d   = '0;
            end else if (restart_i) begin
                cnt_d = '0;
                if (inc_i && speed_q != SMAX) speed_d = speed_q + 3'd1;
            end else if (inc_i || dec_i) begin
                if (step_o) begin
                    cnt_d = '0;
                    if (inc_i && speed_q != SMAX)       speed_d = speed_q + 3'd1;
                    else if (dec_i && speed_q != 3'd0)  speed_d = speed_q - 3'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            speed_q <= '0;
            cnt_q   <= '0;
        end else begin
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
        end
    end

    assign speed_o   = speed_q;
    assign speed_d_o = speed_d;

endmodule

// File: rtl/mario_x_motion.sv
// Per-frame horizontal motion: run/skid FSM, collision stop, position clamp and right scroll.
module mario_x_motion
    import mario_pkg::*;
#(
    parameter int unsigned START_X      = 64,
    parameter int unsigned LEFT_BOUND   = mario_pkg::LEFT_BOUND,
    parameter int unsigned RIGHT_BOUND  = mario_pkg::RIGHT_BOUND,
    parameter int unsigned SCROLL_X     = mario_pkg::SCROLL_X,
    parameter int unsigned MAX_OFFSET   = mario_pkg::MAX_OFFSET,
    parameter int unsigned MAX_SPEED    = 4,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        x_collision_left,
    input  logic        x_collision_right,
    output logic [17:0] Ball_X_Pos,
    output logic [17:0] background_offset,
    output logic [2:0]  x_speed,
    output logic        facing_left
);

    localparam coord_t P_START = coord_t'(START_X);
    localparam coord_t P_LB    = coord_t'(LEFT_BOUND);
    localparam coord_t P_RB    = coord_t'(RIGHT_BOUND);
    localparam coord_t P_SX    = coord_t'(SCROLL_X);
    localparam coord_t P_MO    = coord_t'(MAX_OFFSET);

    x_state_t   state_q, state_d;
    coord_t     pos_q, pos_d, off_q, off_d;
    logic       facing_q, facing_d;

    logic       dir_r, dir_l, moving, travel_left, hit;
    logic       r_clear, r_restart, r_inc, r_dec, r_step;
    logic [2:0] speed_q, speed_d;
    coord_t     spd, sum, excess, room;

    assign dir_r = key_right & ~key_left;
    assign dir_l = key_left & ~key_right;

    x_speed_ramp #(
        .MAX_SPEED   (MAX_SPEED),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) u_ramp (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .tick_i   (frame_tick),
        .clear_i  (r_clear),
        .restart_i(r_restart),
        .inc_i    (r_inc),
        .dec_i    (r_dec),
        .speed_o  (speed_q),
        .speed_d_o(speed_d),
        .step_o   (r_step)
    );

    // SKID travel direction is the facing register: speed is nonzero throughout SKID
    always_comb begin
        moving      = 1'b1;
        travel_left = 1'b0;
        case (state_q)
            STAND: begin
                moving      = dir_r | dir_l;
                travel_left = dir_l;
            end
            RUN_R:   travel_left = 1'b0;
            RUN_L:   travel_left = 1'b1;
            SKID:    travel_left = facing_q;
            default: moving      = 1'b0;
        endcase
        hit = moving & (travel_left ? x_collision_left : x_collision_right);
    end

    always_comb begin
        state_d   = state_q;
        r_clear   = 1'b0;
        r_restart = 1'b0;
        r_inc     = 1'b0;
        r_dec     = 1'b0;
        if (hit) begin
            r_clear = 1'b1;
            state_d = STAND;
        end else begin
            case (state_q)
                STAND: begin
                    if (dir_r || dir_l) begin
                        state_d   = dir_r ? RUN_R : RUN_L;
                        r_restart = 1'b1;
                        r_inc     = 1'b1;
                    end
                end
                RUN_R, RUN_L: begin
                    if ((state_q == RUN_R && dir_r) || (state_q == RUN_L && dir_l)) begin
                        r_inc = 1'b1;
                    end else begin
                        state_d   = SKID;
                        r_restart = 1'b1;
                    end
                end
                SKID: begin
                    if (travel_left ? dir_l : dir_r) begin
                        state_d   = travel_left ? RUN_L : RUN_R;
                        r_restart = 1'b1;
                    end else begin
                        r_dec = 1'b1;
                        if (r_step && speed_q == 3'd1) state_d = STAND;
                    end
                end
                default: state_d = STAND;
            endcase
        end
    end

    // Scroll absorbs only the part of the step past SCROLL_X; any excess beyond MAX_OFFSET moves the sprite
    always_comb begin
        pos_d    = pos_q;
        off_d    = off_q;
        facing_d = facing_q;
        spd      = {15'd0, speed_d};
        sum      = pos_q + spd;
        excess   = sum - P_SX;
        room     = P_MO - off_q;
        if (!hit && speed_d != 3'd0) begin
            facing_d = travel_left;
            if (travel_left) begin
                pos_d = (pos_q >= P_LB + spd) ? pos_q - spd : P_LB;
            end else if (off_q == P_MO || sum <= P_SX) begin
                pos_d = (sum > P_RB) ? P_RB : sum;
            end else if (excess <= room) begin
                off_d = off_q + excess;
                pos_d = P_SX;
            end else begin
                off_d = P_MO;
                pos_d = P_SX + (excess - room);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= STAND;
            pos_q    <= P_START;
            off_q    <= '0;
            facing_q <= 1'b0;
        end else if (frame_tick) begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            off_q    <= off_d;
            facing_q <= facing_d;
        end
    end

    assign Ball_X_Pos        = pos_q;
    assign background_offset = off_q;
    assign x_speed           = speed_q;
    assign facing_left       = facing_q;

endmodule
